accel_mem_arb: RTL and testbench
================================

ACCEL_MEM_ARB -- requirements
Module: accel_mem_arb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_WIDTH, 32, RAM word-address width.
- DATA_WIDTH, 32, RAM data width.
- MAX_BURST, 16, max consecutive locked accelerator grants while CPU waits (2..255).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- cpu_req, in, 1, CPU transfer request.
- cpu_addr / cpu_wdata / cpu_be / cpu_we, in, ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8 / 1, CPU transfer fields.
- cpu_gnt, out, 1, CPU transfer accepted this cycle.
- cpu_rvalid, out, 1, response for a CPU transfer granted last cycle.
- cpu_rdata, out, DATA_WIDTH, read data.
- acc_req, acc_lock, in, 1 each, accelerator request; burst-hold hint.
- acc_addr / acc_wdata / acc_be / acc_we, in, same widths as CPU fields, accelerator transfer fields.
- acc_gnt / acc_rvalid / acc_rdata, out, 1 / 1 / DATA_WIDTH, accelerator handshake.
- mem_en / mem_we, out, 1 each, RAM port A enable and write enable.
- mem_addr / mem_wdata / mem_be, out, ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8, RAM port A fields.
- mem_rdata, in, DATA_WIDTH, RAM read data, one-cycle latency.
- conflict_cnt, out, 16, saturating count of cycles with both requests active.

Function
REQ-003 At most one of cpu_gnt, acc_gnt SHALL be high per cycle; gnt is combinational, same cycle as req.
REQ-004 A requester's gnt SHALL NOT assert unless its req is high.
REQ-005 Only one requester active -> that requester SHALL be granted.
REQ-006 Both active: ACC SHALL be granted if the previous grant was ACC, acc_lock=1, and burst_cnt < MAX_BURST.
REQ-007 Otherwise, both active: the requester not granted most recently (last_gnt) SHALL be granted (round robin).
REQ-008 Granted cycle: mem_en=1 and mem_addr/mem_wdata/mem_be/mem_we SHALL equal the winner's fields.
REQ-009 No grant: mem_en=0 and mem_we=0; other mem_* don't-care.
REQ-010 last_gnt register SHALL update only on a grant (owner CPU or ACC).
REQ-011 burst_cnt (8 bit) SHALL increment on an ACC grant with acc_lock=1, saturating at MAX_BURST.
REQ-012 burst_cnt SHALL clear on any CPU grant and on any ACC grant with acc_lock=0; otherwise hold.
REQ-013 Every grant (read or write) SHALL produce <req>_rvalid=1 exactly one cycle later, one cycle wide per grant.
REQ-014 <req>_rdata SHALL equal mem_rdata while <req>_rvalid=1; otherwise 0.
REQ-015 Back-to-back grants to alternating owners SHALL route rvalid/rdata to the correct owner each cycle via a registered owner tag.
REQ-016 conflict_cnt SHALL increment each cycle with cpu_req=1 and acc_req=1, saturating at 16'hFFFF.
REQ-017 Requester changing fields while not granted is legal; fields sampled only in the granted cycle.

Reset
REQ-018 While rst=1: cpu_gnt=acc_gnt=0, mem_en=mem_we=0, regardless of req inputs.
REQ-019 On a clk edge with rst=1: cpu_rvalid=acc_rvalid=0, rdata=0, burst_cnt=0, conflict_cnt=0, last_gnt=CPU.
REQ-020 Reset mid-burst SHALL drop any pending rvalid; first cycle after reset with both requests active SHALL grant ACC.

Verification
REQ-021 Scenario: reset, then cpu_req=1 only, read addr 0x10, RAM word 0xDEADBEEF -> cpu_gnt=1 same cycle, mem_en=1, mem_addr=0x10; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
REQ-022 Scenario: both requesting every cycle, acc_lock=0, 6 cycles after reset -> grants ACC,CPU,ACC,CPU,ACC,CPU; conflict_cnt=6.
REQ-023 Scenario: both requesting, acc_lock=1, MAX_BURST=16 -> 16 consecutive acc_gnt, then cpu_gnt; pattern repeats; burst_cnt cleared after CPU grant.
REQ-024 Scenario: alternating read grants ACC(addr 1), CPU(addr 2) with RAM data 0xA, 0xB -> acc_rvalid with 0xA, then cpu_rvalid with 0xB; never both high.
REQ-025 Scenario: rst asserted in cycle right after an acc grant -> acc_rvalid stays 0; after release with both requesting, acc_gnt=1 first.
REQ-026 Scenario: force conflict for 70000 cycles -> conflict_cnt=16'hFFFF and holds.

Source files
------------

// File: rtl/accel_mem_arb.sv
// Two-requester arbiter in front of a single-port RAM.
// A CPU and an accelerator compete for RAM port A. Grants are combinational.
// Read responses return one cycle after the grant. A registered owner tag routes
// each response to the requester that won the grant.
// The accelerator may keep the port for a bounded burst while acc_lock is held.
module accel_mem_arb #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    cpu_req,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_be,
  input  logic                    cpu_we,
  output logic                    cpu_gnt,
  output logic                    cpu_rvalid,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,

  input  logic                    acc_req,
  input  logic                    acc_lock,
  input  logic [ADDR_WIDTH-1:0]   acc_addr,
  input  logic [DATA_WIDTH-1:0]   acc_wdata,
  input  logic [DATA_WIDTH/8-1:0] acc_be,
  input  logic                    acc_we,
  output logic                    acc_gnt,
  output logic                    acc_rvalid,
  output logic [DATA_WIDTH-1:0]   acc_rdata,

  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,

  output logic [15:0]             conflict_cnt
);

  typedef enum logic {
    OwnCpu = 1'b0,
    OwnAcc = 1'b1
  } owner_e;

  localparam logic [7:0]  MaxBurst = 8'(MAX_BURST);
  localparam logic [15:0] CntMax   = 16'hFFFF;

  owner_e      last_gnt_q;
  logic [7:0]  burst_cnt_q;
  logic        rsp_valid_q;
  owner_e      rsp_owner_q;
  logic [15:0] conflict_cnt_q;

  logic both_req;
  logic acc_hold;
  logic cpu_win;
  logic acc_win;

  // Winner selection: burst hold first, then round robin on conflict.
  always_comb begin
    both_req = cpu_req & acc_req;
    acc_hold = (last_gnt_q == OwnAcc) & acc_lock & (burst_cnt_q < MaxBurst);
    cpu_win  = 1'b0;
    acc_win  = 1'b0;
    if (!rst) begin
      if (both_req) begin
        if (acc_hold) begin
          acc_win = 1'b1;
        end else if (last_gnt_q == OwnAcc) begin
          cpu_win = 1'b1;
        end else begin
          acc_win = 1'b1;
        end
      end else begin
        cpu_win = cpu_req;
        acc_win = acc_req;
      end
    end
  end

  assign cpu_gnt = cpu_win;
  assign acc_gnt = acc_win;

  // RAM port mux; fields are zeroed when idle to keep the bus quiet.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (cpu_win) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_be    = cpu_be;
    end else if (acc_win) begin
      mem_en    = 1'b1;
      mem_we    = acc_we;
      mem_addr  = acc_addr;
      mem_wdata = acc_wdata;
      mem_be    = acc_be;
    end
  end

  // Arbitration history: most recent owner and length of the current locked burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q  <= OwnCpu;
      burst_cnt_q <= 8'd0;
    end else if (cpu_win) begin
      last_gnt_q  <= OwnCpu;
      burst_cnt_q <= 8'd0;
    end else if (acc_win) begin
      last_gnt_q <= OwnAcc;
      if (!acc_lock) begin
        burst_cnt_q <= 8'd0;
      end else if (burst_cnt_q < MaxBurst) begin
        burst_cnt_q <= burst_cnt_q + 8'd1;
      end
    end
  end

  // Response tracking: one pending response per grant, tagged with its owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= OwnCpu;
    end else begin
      rsp_valid_q <= cpu_win | acc_win;
      rsp_owner_q <= acc_win ? OwnAcc : OwnCpu;
    end
  end

  // Saturating count of cycles where both sides want the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= 16'd0;
    end else if (both_req && (conflict_cnt_q != CntMax)) begin
      conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_q;

  // Response outputs are masked during reset so a response in flight when
  // reset hits is never presented.
  always_comb begin
    cpu_rvalid = rsp_valid_q & (rsp_owner_q == OwnCpu) & ~rst;
    acc_rvalid = rsp_valid_q & (rsp_owner_q == OwnAcc) & ~rst;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    acc_rdata  = acc_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_accel_mem_arb.sv
// Scoreboard bench for accel_mem_arb: the driver checks grants and pushes expected
// responses; a monitor pops them whenever an rvalid appears.
module tb_accel_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        acc_req, acc_lock, acc_we, acc_gnt, acc_rvalid;
  logic [31:0] acc_addr, acc_wdata, acc_rdata;
  logic [3:0]  acc_be;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;
  logic [15:0] conflict_cnt;

  accel_mem_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_we(cpu_we), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .acc_req(acc_req), .acc_lock(acc_lock), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_be(acc_be), .acc_we(acc_we), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid),
    .acc_rdata(acc_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, read-before-write, byte enables.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr[7:0]];
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
      end
    end
  end

  typedef struct {
    int          due;
    bit          acc;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: response routing and data against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (cpu_rvalid === 1'b1 && acc_rvalid === 1'b1) begin
        fails++;
        $display("FAIL both_rvalid: got cpu=%b acc=%b, want at most one", cpu_rvalid, acc_rvalid);
      end
      while (q.size() > 0 && q[0].due < cyc) begin
        fails++;
        $display("FAIL missing_rvalid: got none, want response due cycle %0d", q[0].due);
        void'(q.pop_front());
      end
      if (cpu_rvalid === 1'b1 || acc_rvalid === 1'b1) begin
        tests++;
        if (q.size() == 0 || q[0].due != cyc) begin
          fails++;
          $display("FAIL unexpected_rvalid: got cpu=%b acc=%b, want none at cycle %0d",
                   cpu_rvalid, acc_rvalid, cyc);
        end else begin
          mon_e = q.pop_front();
          if (acc_rvalid !== mon_e.acc || cpu_rvalid !== !mon_e.acc) begin
            fails++;
            $display("FAIL rvalid_owner: got cpu=%b acc=%b, want acc=%b",
                     cpu_rvalid, acc_rvalid, mon_e.acc);
          end else if ((mon_e.acc ? acc_rdata : cpu_rdata) !== mon_e.data ||
                       (mon_e.acc ? cpu_rdata : acc_rdata) !== 32'h0) begin
            fails++;
            $display("FAIL rdata: got cpu=%h acc=%h, want %h on acc=%b",
                     cpu_rdata, acc_rdata, mon_e.data, mon_e.acc);
          end
        end
      end else begin
        tests++;
        if (cpu_rdata !== 32'h0 || acc_rdata !== 32'h0) begin
          fails++;
          $display("FAIL idle_rdata: got cpu=%h acc=%h, want 0", cpu_rdata, acc_rdata);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          fails++;
          $display("FAIL missing_rvalid: got none, want response at cycle %0d", cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // exp_g: 0 = no grant, 1 = CPU, 2 = ACC; exp_d is the expected response data.
  task automatic check_cycle(input string name, input int exp_g, input logic [31:0] exp_d);
    logic [1:0]  want;
    logic [70:0] fields;
    exp_t        e;
    @(negedge clk);
    want = (exp_g == 1) ? 2'b10 : (exp_g == 2) ? 2'b01 : 2'b00;
    tests++;
    if ({cpu_gnt, acc_gnt} !== want) begin
      fails++;
      $display("FAIL %s gnt: got cpu/acc=%b, want %b", name, {cpu_gnt, acc_gnt}, want);
    end
    if (exp_g == 0) begin
      chk({name, " mem_idle"}, {30'h0, mem_en, mem_we}, 32'h0);
    end else begin
      fields = (exp_g == 1) ? {1'b1, cpu_we, cpu_addr, cpu_be, cpu_wdata}
                            : {1'b1, acc_we, acc_addr, acc_be, acc_wdata};
      tests++;
      if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata} !== fields) begin
        fails++;
        $display("FAIL %s mem_fields: got %h, want %h", name,
                 {mem_en, mem_we, mem_addr, mem_be, mem_wdata}, fields);
      end
      e.due  = cyc + 1;
      e.acc  = (exp_g == 2);
      e.data = exp_d;
      q.push_back(e);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic cr, input logic ar, input logic lk);
    next();
    rst      = 1'b0;
    cpu_req  = cr;
    acc_req  = ar;
    acc_lock = lk;
  endtask

  task automatic do_reset();
    next();
    rst     = 1'b1;
    cpu_req = 1'b0;
    acc_req = 1'b0;
    q.delete();
    check_cycle("in_reset", 0, 32'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 + i;
    ram[8'h10] = 32'hDEADBEEF;
    ram[8'h01] = 32'h0000_000A;
    ram[8'h02] = 32'h0000_000B;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_be = 4'hF;
    acc_req = 1'b0; acc_lock = 1'b0; acc_we = 1'b0; acc_addr = 32'h0;
    acc_wdata = 32'h0; acc_be = 4'hF;

    // Requests held high during reset must not be granted.
    next(); cpu_req = 1'b1; acc_req = 1'b1;
    check_cycle("reset_req", 0, 32'h0);
    next();
    check_cycle("reset_req2", 0, 32'h0);
    go(1'b0, 1'b0, 1'b0);
    check_cycle("idle0", 0, 32'h0);
    chk("conflict_after_reset", {16'h0, conflict_cnt}, 32'h0);

    // CPU-only read, write with partial byte enables, then read back.
    go(1'b1, 1'b0, 1'b0); cpu_addr = 32'h10;
    check_cycle("cpu_rd", 1, 32'hDEADBEEF);
    go(1'b0, 1'b0, 1'b0);
    check_cycle("idle1", 0, 32'h0);
    go(1'b1, 1'b0, 1'b0);
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hFFFF55AA; cpu_be = 4'b0011;
    check_cycle("cpu_wr", 1, 32'h1000_0020);
    go(1'b1, 1'b0, 1'b0); cpu_we = 1'b0; cpu_be = 4'hF;
    check_cycle("cpu_rdback", 1, 32'h1000_55AA);

    // Accelerator-only read while CPU fields wander.
    go(1'b0, 1'b1, 1'b0); acc_addr = 32'h30; cpu_addr = 32'h77;
    check_cycle("acc_rd", 2, 32'h1000_0030);
    go(1'b0, 1'b0, 1'b0);
    check_cycle("idle2", 0, 32'h0);

    // Round robin without lock: ACC first after reset, strictly alternating.
    do_reset();
    cpu_addr = 32'h2; acc_addr = 32'h1;
    for (int i = 0; i < 6; i++) begin
      go(1'b1, 1'b1, 1'b0);
      check_cycle("rr", (i % 2 == 0) ? 2 : 1, (i % 2 == 0) ? 32'hA : 32'hB);
    end
    go(1'b0, 1'b0, 1'b0);
    check_cycle("idle3", 0, 32'h0);
    chk("conflict_rr", {16'h0, conflict_cnt}, 32'd6);

    // Locked bursts: 16 ACC grants then one CPU grant, twice.
    do_reset();
    for (int i = 0; i < 34; i++) begin
      go(1'b1, 1'b1, 1'b1);
      check_cycle("burst", (i % 17 == 16) ? 1 : 2, (i % 17 == 16) ? 32'hB : 32'hA);
    end
    go(1'b0, 1'b0, 1'b0);
    check_cycle("idle4", 0, 32'h0);
    chk("conflict_burst", {16'h0, conflict_cnt}, 32'd34);

    // Reset right after an ACC grant drops its response; ACC wins first after.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      go(1'b0, 1'b1, 1'b1);
      check_cycle("pre_rst_acc", 2, 32'hA);
    end
    next(); rst = 1'b1; cpu_req = 1'b1; acc_req = 1'b1; q.delete();
    check_cycle("mid_burst_rst", 0, 32'h0);
    go(1'b1, 1'b1, 1'b1);
    check_cycle("post_rst_first", 2, 32'hA);
    go(1'b1, 1'b1, 1'b1);
    check_cycle("post_rst_hold", 2, 32'hA);
    go(1'b1, 1'b1, 1'b0);
    check_cycle("post_rst_unlock", 1, 32'hB);
    go(1'b0, 1'b0, 1'b0);
    check_cycle("idle5", 0, 32'h0);
    chk("conflict_post_rst", {16'h0, conflict_cnt}, 32'd3);

    // Long conflict run saturates the counter.
    do_reset();
    mon_en = 1'b0;
    for (int i = 0; i < 70000; i++) go(1'b1, 1'b1, 1'b0);
    go(1'b0, 1'b0, 1'b0);
    check_cycle("idle6", 0, 32'h0);
    go(1'b0, 1'b0, 1'b0);
    q.delete();
    mon_en = 1'b1;
    check_cycle("idle7", 0, 32'h0);
    chk("conflict_sat", {16'h0, conflict_cnt}, 32'h0000_FFFF);
    go(1'b1, 1'b1, 1'b0);
    check_cycle("post_sat", 2, 32'hA);
    go(1'b0, 1'b0, 1'b0);
    check_cycle("idle8", 0, 32'h0);
    chk("conflict_hold", {16'h0, conflict_cnt}, 32'h0000_FFFF);

    go(1'b0, 1'b0, 1'b0);
    check_cycle("idle9", 0, 32'h0);
    chk("scoreboard_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
